vga_timing: RTL

Generates 800x600 @ 60 Hz VGA raster timing from a 40 MHz pixel clock. It is the stage directly upstream of the border and arena drawing logic. It drives the `row`/`col` pixel coordinates that those stages consume, plus the sync and blanking strobes sent to the DAC/connector. An optional game tick, derived from frame boundaries, paces the Tron game logic.

---
 rtl/vga_timing_if.sv | 31 +++
 rtl/vga_timing.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Raster output bundle from vga_timing to the draw stages and the DAC/connector.
// The timing generator drives it through the master modport; consumers use slave.
interface vga_timing_if;
    logic [9:0] row;
    logic [9:0] col;
    logic       HS;
    logic       VS;
    logic       blank;
    logic       frame_start;
    logic       game_tick;

    modport master (
        output row,
        output col,
        output HS,
        output VS,
        output blank,
        output frame_start,
        output game_tick
    );

    modport slave (
        input  row,
        input  col,
        input  HS,
        input  VS,
        input  blank,
        input  frame_start,
        input  game_tick
    );
endinterface

// File: rtl/vga_timing.sv
// 800x600@60 raster timing: h/v counters with registered, zero-skew pixel decode.
// Define VGA_GAME_TICK_EN to build the frame-paced game tick; otherwise game_tick is 0.
module vga_timing #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned H_FP        = 40,
    parameter int unsigned H_SYNC      = 128,
    parameter int unsigned H_BP        = 88,
    parameter int unsigned V_ACTIVE    = 600,
    parameter int unsigned V_FP        = 1,
    parameter int unsigned V_SYNC      = 4,
    parameter int unsigned V_BP        = 23,
    parameter int unsigned TICK_FRAMES = 4
) (
    input  logic         clock,
    input  logic         reset,
    vga_timing_if.master vga_o
);
    localparam int unsigned H_W      = 11;
    localparam int unsigned V_W      = 10;
    localparam int unsigned C_W      = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_BEGIN + H_SYNC;
    localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_BEGIN + V_SYNC;

    // Geometries the fixed counter widths cannot hold are rejected at elaboration.
    if (H_TOTAL > 2048 || H_TOTAL == 0) begin : g_bad_h_total
        $error("vga_timing: H_TOTAL=%0d outside 1..2048", H_TOTAL);
    end
    if (V_TOTAL > 1024 || V_TOTAL == 0) begin : g_bad_v_total
        $error("vga_timing: V_TOTAL=%0d outside 1..1024", V_TOTAL);
    end
    if (H_ACTIVE > 1024) begin : g_bad_h_active
        $error("vga_timing: H_ACTIVE=%0d exceeds 1024", H_ACTIVE);
    end
    if (TICK_FRAMES < 1 || TICK_FRAMES > 255) begin : g_bad_tick
        $error("vga_timing: TICK_FRAMES=%0d outside 1..255", TICK_FRAMES);
    end

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    logic [V_W-1:0] row_q, row_d;
    logic [C_W-1:0] col_q, col_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           blank_q, blank_d;
    logic           fs_q, fs_d;

    // Raster position of the next cycle; v advances only on the line wrap.
    always_comb begin
        h_d = h_q + H_W'(1);
        v_d = v_q;
        if (h_q == H_W'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == V_W'(V_TOTAL - 1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + V_W'(1);
            end
        end
    end

    // Decode from the next position so every registered output describes the same pixel.
    always_comb begin
        row_d   = v_d;
        col_d   = '0;
        if (32'(h_d) < H_ACTIVE) begin
            col_d = h_d[C_W-1:0];
        end
        hs_d    = (32'(h_d) >= HS_BEGIN) && (32'(h_d) < HS_END);
        vs_d    = (32'(v_d) >= VS_BEGIN) && (32'(v_d) < VS_END);
        blank_d = (32'(h_d) >= H_ACTIVE) || (32'(v_d) >= V_ACTIVE);
        fs_d    = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            blank_q <= 1'b0;
            fs_q    <= 1'b1;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VGA_GAME_TICK_EN
    localparam int unsigned T_W = 8;

    logic [T_W-1:0] tick_cnt_q, tick_cnt_d;
    logic           tick_q, tick_d;

    // Frames seen since the last tick; the tick lands on the frame_start that completes a group.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (fs_q) begin
            if (tick_cnt_q == T_W'(TICK_FRAMES - 1)) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + T_W'(1);
            end
        end
        tick_d = fs_d && (tick_cnt_d == T_W'(TICK_FRAMES - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign vga_o.game_tick = tick_q;
`else
    assign vga_o.game_tick = 1'b0;
`endif

    assign vga_o.row         = row_q;
    assign vga_o.col         = col_q;
    assign vga_o.HS          = hs_q;
    assign vga_o.VS          = vs_q;
    assign vga_o.blank       = blank_q;
    assign vga_o.frame_start = fs_q;
endmodule
